// File: rtl/tbl_pkg.sv
// Shared types and defaults for the range-copy table.
// State encoding and default geometry live here.
package tbl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } tbl_state_e;

  localparam int TBL_DEPTH = 4;
  localparam int TBL_WIDTH = 4;

endpackage

// File: rtl/tbl_regfile.sv
// DEPTH x WIDTH storage, one write port, two async read ports.
// Cleared on reset; reads see the contents after the last edge.
module tbl_regfile
  import tbl_pkg::*;
#(
  parameter  int DEPTH = TBL_DEPTH,
  parameter  int WIDTH = TBL_WIDTH,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             i_we,
  input  logic [IDXW-1:0]  i_widx,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDXW-1:0]  i_ra_idx,
  output logic [WIDTH-1:0] o_ra_data,
  input  logic [IDXW-1:0]  i_rb_idx,
  output logic [WIDTH-1:0] o_rb_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_mem <= '{default: '0};
    end else if (i_we && (int'(i_widx) < DEPTH)) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Out-of-range indices (non power-of-two DEPTH) read as zero
  assign o_ra_data = (int'(i_ra_idx) < DEPTH) ? r_mem[i_ra_idx] : '0;
  assign o_rb_data = (int'(i_rb_idx) < DEPTH) ? r_mem[i_rb_idx] : '0;

endmodule

// File: rtl/tbl_range_copy.sv
// Table with host write port and a one-entry-per-clock range copy.
// Copies a snapshot of table[src_idx] into lo..hi inclusive.
module tbl_range_copy
  import tbl_pkg::*;
#(
  parameter  int DEPTH = TBL_DEPTH,
  parameter  int WIDTH = TBL_WIDTH,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [IDXW-1:0]  lo,
  input  logic [IDXW-1:0]  hi,
  input  logic [IDXW-1:0]  src_idx,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [IDXW:0]    copied_cnt
);

  localparam logic [IDXW:0] W_DEPTH = (IDXW+1)'(DEPTH);

  tbl_state_e       r_state;
  tbl_state_e       w_state_nx;
  logic [IDXW-1:0]  r_i;
  logic [IDXW-1:0]  r_hi;
  logic [WIDTH-1:0] r_src;
  logic [IDXW:0]    r_cnt;
  logic [IDXW:0]    r_copied;
  logic             r_busy;

  logic             w_we;
  logic [IDXW-1:0]  w_widx;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_src_rd;
  logic [WIDTH-1:0] w_src_val;
  logic             w_empty;
  logic             w_last;

  tbl_regfile #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_rf (
    .clk      (clk),
    .reset_l  (reset_l),
    .i_we     (w_we),
    .i_widx   (w_widx),
    .i_wdata  (w_wdata),
    .i_ra_idx (rd_idx),
    .o_ra_data(rd_data),
    .i_rb_idx (src_idx),
    .o_rb_data(w_src_rd)
  );

  // Same-cycle host write to the source wins over the stored value
  assign w_src_val = (wr_en && (wr_idx == src_idx)) ? wr_data : w_src_rd;
  assign w_empty   = (lo > hi) || ({1'b0, hi} >= W_DEPTH);
  assign w_last    = (r_i == r_hi);

  always_comb begin
    w_state_nx = r_state;
    w_we       = 1'b0;
    w_widx     = wr_idx;
    w_wdata    = wr_data;
    unique case (r_state)
      IDLE: begin
        w_we = wr_en;
        if (start) begin
          w_state_nx = w_empty ? DONE : COPY;
        end
      end
      COPY: begin
        w_we    = 1'b1;
        w_widx  = r_i;
        w_wdata = r_src;
        if (w_last) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_i      <= '0;
      r_hi     <= '0;
      r_src    <= '0;
      r_cnt    <= '0;
      r_copied <= '0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_i   <= lo;
            r_hi  <= hi;
            r_src <= w_src_val;
            r_cnt <= '0;
            if (w_empty) begin
              r_copied <= '0;
            end
          end
        end
        COPY: begin
          r_cnt <= r_cnt + 1'b1;
          // Compare before increment so i never wraps past hi
          if (w_last) begin
            r_copied <= r_cnt + 1'b1;
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = (r_state == DONE);
  assign copied_cnt = r_copied;

endmodule

// File: doc/tbl_range_copy.md
Name: tbl_range_copy

Overview:
- Small register-file table with a direct host write port and a sequential range-copy engine.
- The engine copies one source entry into every index `i` with `lo <= i <= hi`, one entry per clock.
- It is the loader and update stage that produces the table contents a downstream loop-style consumer reads.
- Empty or inverted ranges complete with zero writes, matching the semantics of a loop whose condition is false on entry.

Parameters:
- DEPTH, 4, number of table entries.
- WIDTH, 4, bits per entry.
- IDXW, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset_l  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe; honoured only when idle.
- wr_idx  in  IDXW  host write index.
- wr_data  in  WIDTH  host write data.
- start  in  1  range-copy request; honoured only when idle.
- lo  in  IDXW  first index of the range, inclusive.
- hi  in  IDXW  last index of the range, inclusive.
- src_idx  in  IDXW  index of the source entry.
- rd_idx  in  IDXW  read index.
- rd_data  out  WIDTH  combinational read of the table at `rd_idx`.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle completion pulse.
- copied_cnt  out  IDXW+1  number of entries written by the last completed operation.

Behaviour:
- Reset (reset_l low, asynchronous):
  - All table entries clear to 0; state goes to IDLE.
  - `busy`=0, `done`=0, `copied_cnt`=0.
  - Reset mid-copy aborts the operation; no done pulse is produced.
- States: IDLE, COPY, DONE.
- IDLE:
  - `wr_en` writes `table[wr_idx] <= wr_data`.
  - `start` sampled high at edge E0:
    - Latches `lo`, `hi` and `src_val`.
    - `src_val` is `table[src_idx]` with write bypass: if `wr_en` and `wr_idx==src_idx` in the same cycle, `src_val` = `wr_data`.
    - If `lo>hi` or `hi>=DEPTH`, next state is DONE with count 0.
    - Otherwise next state is COPY with `i=lo`.
- COPY:
  - Each edge writes `table[i] <= src_val` and increments the count.
  - If `i==hi`, next state is DONE; else `i <= i+1`.
  - The source is a snapshot: overwriting `src_idx` mid-range does not change later writes.
- DONE:
  - `done`=1 for exactly one cycle.
  - `copied_cnt` is updated on entry to DONE.
  - Next state is IDLE.
- Latency:
  - For an N-entry range, writes land on edges E1..EN and `done` is high in the cycle after EN.
  - For an empty range, `done` is high in the cycle after E0.
- `busy` = (state != IDLE); it is registered.
- `start` or `wr_en` while busy is ignored and not queued.
- A `start` held high in the DONE cycle is ignored; the next start is accepted in IDLE.
- `i` never wraps: termination is on `i==hi`, compared before increment.
- `rd_data` reflects the table after the most recent edge, with no read-during-write bypass.

Decomposition:
- Shared package tbl_pkg holds:
  - the state enum `tbl_state_e` {IDLE, COPY, DONE};
  - the default constants TBL_DEPTH=4 and TBL_WIDTH=4.
- Natural sub-module: tbl_regfile. It holds the DEPTH×WIDTH storage, has one write port and two combinational read ports (rd_idx and src_idx), and is cleared on reset.
- The copy FSM stays in the top level.

Test Plan:
- Load {0,1,2,3} via `wr_en`. Start with lo=1, hi=3, src=0. Expected: busy for 4 cycles, done one cycle after the third write, table={0,0,0,0}, `copied_cnt`=3.
- Load {0,1,2,3}. Start with lo=0, hi=3, src=2. Expected: table={2,2,2,2}; the snapshot holds even after entry 2 is overwritten; `copied_cnt`=4.
- Load {0,0,2,3}. Start with lo=2, hi=1, src=0 (inverted range, condition false on entry). Expected: done in the cycle after start, `copied_cnt`=0, table unchanged, tmp[0]=0, tmp[3]=3.
- Same cycle in IDLE: wr_en with wr_idx=1 and wr_data=9, plus start with lo=2, hi=3, src=1. Expected: table={x,9,9,9} (bypass); a wr_en to index 0 issued while busy is dropped.
- Assert start with lo=0, hi=3, then drop reset_l after the second write. Expected: all entries read 0, busy=0, no done pulse; a subsequent start with lo=hi=3 writes exactly one entry, `copied_cnt`=1.
- Assert start with lo=hi=0 twice back-to-back, holding start high. Expected: the second start is accepted only after returning to IDLE; two done pulses exactly 3 cycles apart.
